addsub_mp_seq: RTL



---
 rtl/addsub_mp_seq_if.sv | 28 ++
 rtl/addsub_mp_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/addsub_mp_seq_if.sv
// Operand/result handshake bundle for the multi-precision add/sub sequencer.
// The producer/consumer side uses master; the sequencer uses slave.
interface addsub_mp_seq_if #(
  parameter int W = 4,
  parameter int N = 4
);
  logic           IN_VALID;
  logic           IN_READY;
  logic [N*W-1:0] A;
  logic [N*W-1:0] B;
  logic           M;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic [N*W-1:0] S;
  logic           C;
  logic           V;
  logic           Z;

  modport master (
    output IN_VALID, A, B, M, OUT_READY,
    input  IN_READY, OUT_VALID, S, C, V, Z
  );

  modport slave (
    input  IN_VALID, A, B, M, OUT_READY,
    output IN_READY, OUT_VALID, S, C, V, Z
  );
endinterface

// File: rtl/addsub_mp_seq.sv
// Multi-precision adder/subtractor: one W-bit carry-lookahead slice processes
// an N-word operand pair LSW first, chaining the carry through a register.
module addsub_mp_seq #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic            CLK,
  input  logic            RST,
  addsub_mp_seq_if.slave  bus
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_a_w [N];
  logic [W-1:0]     r_b_w [N];
  logic [W-1:0]     r_s_w [N];
  logic             r_m;
  logic             r_carry;
  logic             r_nz;
  logic             r_c;
  logic             r_v;
  logic             r_z;

  logic             w_accept;
  logic             w_release;
  logic             w_last;
  logic [W-1:0]     w_a_k;
  logic [W-1:0]     w_b_k;
  logic [W+1:0]     w_slice;
  logic [W-1:0]     w_sum;
  logic             w_cout;
  logic             w_cmsb;

  // Pure lookahead slice: each carry is a flat sum of products of the
  // generate/propagate terms and cin, never built from the previous carry.
  // Returns {carry out, carry into bit W-1, sum}.
  function automatic logic [W+1:0] cla_slice(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         cin
  );
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         pp;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
    return {c[W], c[W-1], p ^ c[W-1:0]};
  endfunction

  assign w_accept  = (r_state == IDLE) && bus.IN_VALID;
  assign w_release = (r_state == DONE) && bus.OUT_READY;
  assign w_last    = (r_idx == LAST_IDX);

  assign w_a_k   = r_a_w[r_idx];
  assign w_b_k   = r_b_w[r_idx] ^ {W{r_m}};
  assign w_slice = cla_slice(w_a_k, w_b_k, r_carry);
  assign w_sum   = w_slice[W-1:0];
  assign w_cmsb  = w_slice[W];
  assign w_cout  = w_slice[W+1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (w_release) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture: only meaningful on the accept cycle, so no reset.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_m <= bus.M;
      for (int k = 0; k < N; k++) begin
        r_a_w[k] <= bus.A[k*W +: W];
        r_b_w[k] <= bus.B[k*W +: W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_nz    <= 1'b0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
      for (int k = 0; k < N; k++) begin
        r_s_w[k] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx   <= '0;
            r_carry <= bus.M;
            r_nz    <= 1'b0;
          end
        end
        RUN: begin
          r_s_w[r_idx] <= w_sum;
          r_carry      <= w_cout;
          r_nz         <= r_nz | (|w_sum);
          // Flags are taken from the MSW slice; idx parks at N-1 until next accept.
          if (w_last) begin
            r_c <= w_cout;
            r_v <= w_cmsb ^ w_cout;
            r_z <= ~(r_nz | (|w_sum));
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_s_out
    assign bus.S[k*W +: W] = r_s_w[k];
  end

  assign bus.IN_READY  = (r_state == IDLE);
  assign bus.OUT_VALID = (r_state == DONE);
  assign bus.C         = r_c;
  assign bus.V         = r_v;
  assign bus.Z         = r_z;

endmodule
